// File: rtl/fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle floating-point adder/subtractor for an IEEE-754 style format
// {sign, exponent, mantissa}. One operation is in flight at a time. It walks
// IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE and holds the result in DONE
// until the consumer takes it. Rounding is round-to-nearest-even. Denormal
// inputs and results are flushed to signed zero.
//
// Parameters
//   EXP_W     exponent field width
//   MAN_W     stored mantissa width (hidden bit not stored)
//
// Ports
//   clk       clock, all state changes on the rising edge
//   reset     synchronous, active-low
//   in_valid  x, y, sub are presented
//   in_ready  block can accept an operation (IDLE only)
//   x, y      operands
//   sub       0: x+y, 1: x-y
//   out_valid z/flags hold a finished result (DONE only)
//   out_ready consumer takes the result
//   z         result
//   flags     {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [3:0]   flags
);

    // Internal significand: hidden bit, mantissa, guard, round, sticky.
    localparam int SW        = MAN_W + 4;
    localparam int LZ_W      = $clog2(SW + 1);
    localparam int EW        = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam int MAX_SHIFT = MAN_W + 2;

    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_MIN  = EW'(1);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t state, next_state;

    // Captured operands
    logic [W-1:0]            xr, yr;
    logic                    subr;

    // Stage registers
    logic [SW-1:0]           al_big, al_small;
    logic                    al_sign, al_esub;
    logic [EXP_W-1:0]        al_exp;
    logic                    sp_en;
    logic [W-1:0]            sp_z;
    logic [3:0]              sp_f;
    logic [SW:0]             ad_sum;
    logic                    ad_sign;
    logic [EXP_W-1:0]        ad_exp;
    logic [SW-1:0]           nm_sig;
    logic signed [EW-1:0]    nm_exp;
    logic                    nm_sign;
    logic [W-1:0]            z_r;
    logic [3:0]              flags_r;

    // Operand unpacking; y's sign is flipped for subtraction
    logic                    xs, ys;
    logic [EXP_W-1:0]        xe, ye;
    logic [MAN_W-1:0]        xm, ym;

    assign {xs, xe, xm} = xr;
    assign ys = yr[W-1] ^ subr;
    assign ye = yr[W-2:MAN_W];
    assign ym = yr[MAN_W-1:0];

    // ALIGN combinational
    logic                    x_inf, y_inf, x_nan, y_nan, x_snan, y_snan, swap;
    logic [EXP_W+MAN_W-1:0]  x_mag, y_mag;
    logic [MAN_W:0]          x_sig, y_sig, big_sig, small_sig;
    logic [EXP_W-1:0]        big_exp, small_exp, exp_diff;
    logic [2*SW-1:0]         shift_wide;
    logic [SW-1:0]           small_al;
    logic                    c_sp_en;
    logic [W-1:0]            c_sp_z;
    logic [3:0]              c_sp_f;

    // Classify operands, order by magnitude and align the smaller one.
    // Denormals get magnitude and significand zero so they behave as zero.
    always_comb begin
        x_inf  = (xe == EXP_ONES) && (xm == '0);
        y_inf  = (ye == EXP_ONES) && (ym == '0);
        x_nan  = (xe == EXP_ONES) && (xm != '0);
        y_nan  = (ye == EXP_ONES) && (ym != '0);
        x_snan = x_nan && !xm[MAN_W-1];
        y_snan = y_nan && !ym[MAN_W-1];

        x_mag  = (xe == '0) ? '0 : {xe, xm};
        y_mag  = (ye == '0) ? '0 : {ye, ym};
        x_sig  = (xe == '0) ? '0 : {1'b1, xm};
        y_sig  = (ye == '0) ? '0 : {1'b1, ym};

        swap      = y_mag > x_mag;
        big_sig   = swap ? y_sig : x_sig;
        small_sig = swap ? x_sig : y_sig;
        big_exp   = swap ? ye : xe;
        small_exp = swap ? xe : ye;
        exp_diff  = big_exp - small_exp;

        // Bits pushed below the round position land in the low half and
        // collapse into the sticky bit.
        shift_wide = {small_sig, 3'b000, {SW{1'b0}}} >> exp_diff;
        if (int'(exp_diff) > MAX_SHIFT)
            small_al = {{(SW-1){1'b0}}, |small_sig};
        else
            small_al = shift_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |shift_wide[SW-1:0]};

        c_sp_en = 1'b0;
        c_sp_z  = '0;
        c_sp_f  = '0;
        if (x_nan || y_nan) begin
            c_sp_en = 1'b1;
            c_sp_z  = QNAN;
            c_sp_f  = {x_snan | y_snan, 3'b000};
        end else if (x_inf && y_inf && (xs != ys)) begin
            c_sp_en = 1'b1;
            c_sp_z  = QNAN;
            c_sp_f  = 4'b1000;
        end else if (x_inf) begin
            c_sp_en = 1'b1;
            c_sp_z  = {xs, EXP_ONES, {MAN_W{1'b0}}};
        end else if (y_inf) begin
            c_sp_en = 1'b1;
            c_sp_z  = {ys, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // ADD combinational: big >= small, so the difference never goes negative
    logic [SW:0] sum_c;

    always_comb begin
        if (al_esub)
            sum_c = {1'b0, al_big} - {1'b0, al_small};
        else
            sum_c = {1'b0, al_big} + {1'b0, al_small};
    end

    // NORM combinational: leading-zero count and single-step normalisation
    logic [LZ_W-1:0]      lzc;
    logic [SW-1:0]        n_sig;
    logic signed [EW-1:0] n_exp, exp_in;

    always_comb begin
        lzc = LZ_W'(SW);
        for (int i = 0; i < SW; i++)
            if (ad_sum[i]) lzc = LZ_W'(SW - 1 - i);
        exp_in = EW'(ad_exp);
        if (ad_sum[SW]) begin
            n_sig = ad_sum[SW:1] | {{(SW-1){1'b0}}, ad_sum[0]};
            n_exp = exp_in + EW'(1);
        end else begin
            n_sig = ad_sum[SW-1:0] << lzc;
            n_exp = exp_in - EW'(lzc);
        end
    end

    // ROUND combinational. A zero sum is the only case whose normalised top
    // bit is clear, so that bit doubles as the zero detect.
    logic                 g, r, s, rnd_up;
    logic [MAN_W:0]       mant_rnd;
    logic signed [EW-1:0] exp_rnd;
    logic [W-1:0]         r_z;
    logic [3:0]           r_f;

    always_comb begin
        g        = nm_sig[2];
        r        = nm_sig[1];
        s        = nm_sig[0];
        rnd_up   = g & (r | s | nm_sig[3]);
        mant_rnd = {1'b0, nm_sig[SW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
        exp_rnd  = nm_exp + {{(EW-1){1'b0}}, mant_rnd[MAN_W]};
        r_z      = '0;
        r_f      = '0;
        if (sp_en) begin
            r_z = sp_z;
            r_f = sp_f;
        end else if (!nm_sig[SW-1]) begin
            r_z = {nm_sign, {(W-1){1'b0}}};
        end else if (exp_rnd >= EXP_MAX) begin
            r_z = {nm_sign, EXP_ONES, {MAN_W{1'b0}}};
            r_f = 4'b0101;
        end else if (exp_rnd < EXP_MIN) begin
            r_z = {nm_sign, {(W-1){1'b0}}};
            r_f = 4'b0011;
        end else begin
            r_z = {nm_sign, exp_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
            r_f = {3'b000, g | r | s};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: fixed walk through the pipeline steps
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = ALIGN;
            ALIGN:   next_state = ADD;
            ADD:     next_state = NORM;
            NORM:    next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath stage registers; each loads only in its own state, so no reset
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (in_valid) begin
                xr   <= x;
                yr   <= y;
                subr <= sub;
            end
            ALIGN: begin
                al_big   <= {big_sig, 3'b000};
                al_small <= small_al;
                al_sign  <= swap ? ys : xs;
                al_esub  <= xs ^ ys;
                al_exp   <= big_exp;
                sp_en    <= c_sp_en;
                sp_z     <= c_sp_z;
                sp_f     <= c_sp_f;
            end
            ADD: begin
                ad_sum  <= sum_c;
                ad_exp  <= al_exp;
                // Exact cancellation gives +0; like-signed zeros keep the sign
                ad_sign <= (sum_c == '0) ? (al_sign & ~al_esub) : al_sign;
            end
            NORM: begin
                nm_sig  <= n_sig;
                nm_exp  <= n_exp;
                nm_sign <= ad_sign;
            end
            default: ;
        endcase
    end

    // Result registers: cleared by reset, flags cleared on accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            z_r     <= '0;
            flags_r <= '0;
        end else if (state == IDLE && in_valid) begin
            flags_r <= '0;
        end else if (state == ROUND) begin
            z_r     <= r_z;
            flags_r <= r_f;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign z         = z_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_seq
// Self-checking bench for fp_addsub_seq. A table of single-precision vectors
// is driven through the default instance; expected results are queued at
// accept and compared by a monitor when the result is taken. Hand-written
// sequences cover backpressure, reset mid-operation and reset in DONE. A
// second, half-precision instance covers the parameter sweep.
// ---------------------------------------------------------------------------
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] x, y, z;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic [15:0] hx, hy, hz;
    logic [3:0]  h_flags;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
        time         acc;
        int          idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    vec_t vecs[26];
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    bit   monitor_on = 1'b1;

    fp_addsub_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .x         (hx),
        .y         (hy),
        .sub       (h_sub),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .z         (hz),
        .flags     (h_flags)
    );

    always #5 clk = ~clk;

    // Safety net in case something wedges outside the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present an operation and return the time of the accepting edge
    task automatic acceptOp(input logic [31:0] ax, input logic [31:0] ay, input logic asub,
                            output time acc, output bit ok);
        int n = 0;
        acc = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            checkOutput("accept timeout", 32'(in_ready), 32'd1);
        end else begin
            x = ax;
            y = ay;
            sub = asub;
            in_valid = 1'b1;
            @(posedge clk);
            acc = $time;
            #1;
            in_valid = 1'b0;
            // Scramble inputs: the block must work from its captured copy
            x = $urandom();
            y = $urandom();
            sub = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        time acc;
        bit  ok;
        acceptOp(v.x, v.y, v.sub, acc, ok);
        if (ok) sb_q.push_back('{v.z, v.f, acc, idx});
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain pending results", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic runHalf(input logic [15:0] ax, input logic [15:0] ay,
                           input logic [15:0] ez, input logic [3:0] ef, input string name);
        int n = 0;
        @(negedge clk);
        checkOutput({name, " ready"}, 32'(h_in_ready), 32'd1);
        hx = ax;
        hy = ay;
        h_sub = 1'b0;
        h_in_valid = 1'b1;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        @(negedge clk);
        while (!h_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " out_valid"}, 32'(h_out_valid), 32'd1);
        checkOutput({name, " z"}, 32'(hz), 32'(ez));
        checkOutput({name, " flags"}, 32'(h_flags), 32'(ef));
        @(posedge clk);
    endtask

    // Scoreboard monitor: latency on first sighting, value when taken
    always @(negedge clk) begin : monitor
        if (monitor_on) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0)
                    checkOutput("unexpected out_valid", 32'(out_valid), 32'd0);
                else
                    checkOutput($sformatf("op%0d latency", sb_q[0].idx),
                                32'($time - sb_q[0].acc), 32'd45);
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                cur = sb_q.pop_front();
                checkOutput($sformatf("op%0d z", cur.idx), z, cur.z);
                checkOutput($sformatf("op%0d flags", cur.idx), 32'(flags), 32'(cur.f));
            end
        end
        if (!out_valid || out_ready) seen = 1'b0;
    end

    initial begin : main
        time acc;
        bit  ok;
        bit  any_valid;
        int  n;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        vecs[3]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1};
        vecs[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        vecs[6]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'h0};
        vecs[7]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0};
        vecs[8]  = '{32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 4'h0};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'h0};
        vecs[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0};
        vecs[12] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};
        vecs[13] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
        vecs[14] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[15] = '{32'h80400000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        vecs[16] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3};
        vecs[17] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'h0};
        vecs[18] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1};
        vecs[19] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
        vecs[20] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'h1};
        vecs[21] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'h1};
        vecs[22] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
        vecs[23] = '{32'h40400000, 32'hC0000000, 1'b0, 32'h3F800000, 4'h0};
        vecs[24] = '{32'hC0400000, 32'h40000000, 1'b1, 32'hC0A00000, 4'h0};
        vecs[25] = '{32'h3F800000, 32'hB3800000, 1'b0, 32'h3F7FFFFF, 4'h0};

        // Reset with in_valid held high: reset must win
        reset = 1'b0;
        in_valid = 1'b1;
        x = 32'h3F800000;
        y = 32'h3F800000;
        sub = 1'b0;
        out_ready = 1'b1;
        h_in_valid = 1'b0;
        hx = '0;
        hy = '0;
        h_sub = 1'b0;
        h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset z", z, 32'd0);
        checkOutput("reset flags", 32'(flags), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 26; i++) applyStimulus(vecs[i], i);
        waitDrain();

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        applyStimulus('{32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 4'h0}, 100);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
            checkOutput($sformatf("hold%0d z", c), z, 32'h40200000);
            checkOutput($sformatf("hold%0d flags", c), 32'(flags), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release in_ready", 32'(in_ready), 32'd1);
        checkOutput("release out_valid", 32'(out_valid), 32'd0);
        waitDrain();

        $display("[TB] reset during NORM");
        acceptOp(32'h3F800000, 32'h3F800000, 1'b0, acc, ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("norm-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("norm-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("norm-reset z", z, 32'd0);
        checkOutput("norm-reset flags", 32'(flags), 32'd0);
        any_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any_valid |= out_valid;
        end
        checkOutput("norm-reset no result", 32'(any_valid), 32'd0);
        applyStimulus('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0}, 200);
        waitDrain();

        $display("[TB] reset in DONE with pending result");
        monitor_on = 1'b0;
        out_ready = 1'b0;
        acceptOp(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, acc, ok);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done-reset reached DONE", 32'(out_valid), 32'd1);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("done-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("done-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("done-reset z", z, 32'd0);
        checkOutput("done-reset flags", 32'(flags), 32'd0);
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_valid |= out_valid;
        end
        checkOutput("done-reset no result", 32'(any_valid), 32'd0);
        monitor_on = 1'b1;

        $display("[TB] half-precision instance");
        runHalf(16'h3C00, 16'h3C00, 16'h4000, 4'h0, "half 1+1");
        runHalf(16'h7BFF, 16'h7BFF, 16'h7C00, 4'h5, "half max+max");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
